// File: rtl/bignum_pkg.sv
// Shared defaults and types for the bignum operand streamer and its neighbours.
package bignum_pkg;

  localparam int unsigned DEFAULT_REGISTER_SIZE = 32;
  localparam int unsigned DEFAULT_BITS_IN_NUM   = 4096;
  localparam int unsigned DEFAULT_NUM_BLOCKS    = DEFAULT_BITS_IN_NUM / DEFAULT_REGISTER_SIZE;

  // Address-issue to data-out latency of the operand BRAM (memory latch + output register).
  localparam int unsigned BRAM_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    STREAM     = 2'd2,
    DRAIN      = 2'd3
  } stream_state_e;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Dual-port read-first block RAM with a registered output stage on each port.
// Port A reads and writes; port B is a read port. Only the output registers reset.
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter  int unsigned RAM_WIDTH = 32,
  parameter  int unsigned RAM_DEPTH = 256,
  localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 clkb,
  input  logic                 rsta,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 enb,
  input  logic                 wea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [ADDR_W-1:0]    addrb,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 regcea,
  input  logic                 regceb,
  output logic [RAM_WIDTH-1:0] douta,
  output logic [RAM_WIDTH-1:0] doutb
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_ram_a;
  logic [RAM_WIDTH-1:0] r_ram_b;

  // Port A: read-first access, old contents are returned on a write.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) r_mem[addra] <= dina;
      r_ram_a <= r_mem[addra];
    end
  end

  // Port B: read-only access.
  always_ff @(posedge clkb) begin
    if (enb) r_ram_b <= r_mem[addrb];
  end

  // Port A output register.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta)        douta <= '0;
    else if (regcea) douta <= r_ram_a;
  end

  // Port B output register.
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb)        doutb <= '0;
    else if (regceb) doutb <= r_ram_b;
  end

endmodule

// File: rtl/bignum_operand_streamer.sv
// Holds operands n and m in one BRAM and streams them LSB block first to the multiplier.
module bignum_operand_streamer
  import bignum_pkg::*;
#(
  parameter  int unsigned REGISTER_SIZE = DEFAULT_REGISTER_SIZE,
  parameter  int unsigned BITS_IN_NUM   = DEFAULT_BITS_IN_NUM,
  localparam int unsigned NUM_BLOCKS    = BITS_IN_NUM / REGISTER_SIZE,
  localparam int unsigned BLK_ADDR_W    = $clog2(NUM_BLOCKS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     wr_en_in,
  input  logic                     wr_sel_in,
  input  logic [BLK_ADDR_W-1:0]    wr_addr_in,
  input  logic [REGISTER_SIZE-1:0] wr_data_in,
  input  logic                     start_in,
  input  logic                     ready_in,
  output logic [REGISTER_SIZE-1:0] n_out,
  output logic [REGISTER_SIZE-1:0] m_out,
  output logic                     valid_out,
  output logic                     busy_out,
  output logic                     done_out
);

  localparam int unsigned RAM_DEPTH = 2 * NUM_BLOCKS;
  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam int unsigned LAT       = BRAM_READ_LATENCY;
  localparam logic [BLK_ADDR_W-1:0] LAST_BLK = BLK_ADDR_W'(NUM_BLOCKS - 1);
  // Pipeline pattern seen when the final beat is on the output and nothing follows it.
  localparam logic [LAT-1:0] VLD_LAST = LAT'(1) << (LAT - 1);

  stream_state_e               r_state;
  stream_state_e               w_state_nxt;
  logic [BLK_ADDR_W-1:0]       r_blk;
  logic [BLK_ADDR_W-1:0]       w_blk_nxt;
  logic [LAT-1:0]              r_vld;
  logic                        r_done;
  logic                        w_done_nxt;
  logic                        r_busy;
  logic                        w_busy_nxt;

  logic                        w_idle;
  logic                        w_stream;
  logic                        w_wea;
  logic                        w_ena;
  logic                        w_regce;
  logic [RAM_AW-1:0]           w_addra;
  logic [RAM_AW-1:0]           w_addrb;
  logic [REGISTER_SIZE-1:0]    w_douta;
  logic [REGISTER_SIZE-1:0]    w_doutb;

  // Port decode: host writes only in IDLE; streaming reads n on A and m on B.
  always_comb begin
    w_idle   = (r_state == IDLE);
    w_stream = (r_state == STREAM);
    w_wea    = wr_en_in && w_idle;
    w_ena    = w_wea || w_stream;
    w_regce  = w_stream || (r_state == DRAIN);
    if (w_idle) w_addra = RAM_AW'(wr_sel_in) * RAM_AW'(NUM_BLOCKS) + RAM_AW'(wr_addr_in);
    else        w_addra = RAM_AW'(r_blk);
    w_addrb = RAM_AW'(NUM_BLOCKS) + RAM_AW'(r_blk);
  end

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH (REGISTER_SIZE),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clka   (clk_in),
    .clkb   (clk_in),
    .rsta   (rst_in),
    .rstb   (rst_in),
    .ena    (w_ena),
    .enb    (w_stream),
    .wea    (w_wea),
    .addra  (w_addra),
    .addrb  (w_addrb),
    .dina   (wr_data_in),
    .regcea (w_regce),
    .regceb (w_regce),
    .douta  (w_douta),
    .doutb  (w_doutb)
  );

  // Next-state, block counter and done/busy decode.
  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) w_state_nxt = WAIT_READY;
      end
      WAIT_READY: begin
        if (ready_in) begin
          w_state_nxt = STREAM;
          w_blk_nxt   = '0;
        end
      end
      STREAM: begin
        // ready_in is deliberately ignored: the multiplier drops it after the first beat.
        w_blk_nxt = r_blk + BLK_ADDR_W'(1);
        if (r_blk == LAST_BLK) begin
          w_state_nxt = DRAIN;
          w_blk_nxt   = '0;
        end
      end
      DRAIN: begin
        w_done_nxt = (r_vld == VLD_LAST);
        if (r_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State, counter and valid/done pipeline registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_vld   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_blk   <= w_blk_nxt;
      r_vld   <= {r_vld[LAT-2:0], w_stream};
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Data is forced to zero off-beat; valid resets asynchronously so outputs clear with reset.
  assign valid_out = r_vld[LAT-1];
  assign n_out     = r_vld[LAT-1] ? w_douta : '0;
  assign m_out     = r_vld[LAT-1] ? w_doutb : '0;
  assign busy_out  = r_busy;
  assign done_out  = r_done;

endmodule

// File: tb/tb_bignum_operand_streamer.sv
// Randomized self-checking bench for bignum_operand_streamer against an array model.
module tb_bignum_operand_streamer;

  localparam int NB = 128;
  localparam int AW = 7;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          wr_en_in = 1'b0;
  logic          wr_sel_in = 1'b0;
  logic [AW-1:0] wr_addr_in = '0;
  logic [31:0]   wr_data_in = '0;
  logic          start_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [31:0]   n_out;
  logic [31:0]   m_out;
  logic          valid_out;
  logic          busy_out;
  logic          done_out;

  bignum_operand_streamer dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_en_in   (wr_en_in),
    .wr_sel_in  (wr_sel_in),
    .wr_addr_in (wr_addr_in),
    .wr_data_in (wr_data_in),
    .start_in   (start_in),
    .ready_in   (ready_in),
    .n_out      (n_out),
    .m_out      (m_out),
    .valid_out  (valid_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference contents of the two operand regions.
  logic [31:0] mdl_n [NB];
  logic [31:0] mdl_m [NB];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic write_block(input bit sel, input int addr, input logic [31:0] data);
    wr_en_in = 1'b1; wr_sel_in = sel; wr_addr_in = AW'(addr); wr_data_in = data;
    tick();
    wr_en_in = 1'b0;
    if (sel) mdl_m[addr] = data; else mdl_n[addr] = data;
  endtask

  // One full start/stream/done sequence, checked beat by beat against the model.
  task automatic run_stream(input int low, input int inj_beat, input int abort_beat,
                            input bit st_wr, input bit st_sel, input int st_addr,
                            input logic [31:0] st_data, input bit start_at_done);
    start_in = 1'b1;
    ready_in = (low == 0);
    if (st_wr) begin
      wr_en_in = 1'b1; wr_sel_in = st_sel; wr_addr_in = AW'(st_addr); wr_data_in = st_data;
      if (st_sel) mdl_m[st_addr] = st_data; else mdl_n[st_addr] = st_data;
    end
    tick();
    start_in = 1'b0; wr_en_in = 1'b0;
    chk("busy_after_start", 32'(busy_out), 32'd1);
    chk("valid_after_start", 32'(valid_out), 32'd0);
    for (int i = 0; i < low; i++) begin
      tick();
      chk("wait_valid_low", 32'(valid_out), 32'd0);
      chk("wait_busy_high", 32'(busy_out), 32'd1);
    end
    ready_in = 1'b1;
    tick();                                      // edge E samples ready
    ready_in = 1'($urandom);
    tick();                                      // E+1: pipeline still filling
    chk("valid_fill", 32'(valid_out), 32'd0);
    for (int k = 0; k < NB; k++) begin
      tick();                                    // E+2+k: beat k
      chk("beat_valid", 32'(valid_out), 32'd1);
      chk($sformatf("beat%0d_n", k), n_out, mdl_n[k]);
      chk($sformatf("beat%0d_m", k), m_out, mdl_m[k]);
      chk("beat_done_low", 32'(done_out), 32'd0);
      wr_en_in = 1'b0; start_in = 1'b0;
      ready_in = 1'($urandom);
      if (k == abort_beat) begin
        #1 rst_in = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_n", n_out, 32'd0);
        chk("rst_m", m_out, 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        @(negedge clk_in);
        tick();
        rst_in = 1'b0; ready_in = 1'b0;
        return;
      end
      if (k == inj_beat) begin
        // Host traffic during the stream must be ignored.
        wr_en_in = 1'b1; wr_sel_in = 1'($urandom); wr_addr_in = AW'(5);
        wr_data_in = 32'hDEAD_BEEF; start_in = 1'b1;
      end
    end
    wr_en_in = 1'b0; start_in = 1'b0; ready_in = 1'b0;
    tick();                                      // done cycle
    chk("done_pulse", 32'(done_out), 32'd1);
    chk("done_valid_low", 32'(valid_out), 32'd0);
    chk("done_busy_high", 32'(busy_out), 32'd1);
    chk("done_n_zero", n_out, 32'd0);
    start_in = start_at_done;
    tick();
    start_in = 1'b0;
    chk("post_done_low", 32'(done_out), 32'd0);
    chk("post_busy_low", 32'(busy_out), 32'd0);
    tick();
    chk("idle_busy_low", 32'(busy_out), 32'd0);
    chk("idle_valid_low", 32'(valid_out), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    #2;
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_busy", 32'(busy_out), 32'd0);
    chk("reset_done", 32'(done_out), 32'd0);
    chk("reset_n", n_out, 32'd0);
    chk("reset_m", m_out, 32'd0);
    @(negedge clk_in);
    tick();
    rst_in = 1'b0;
    tick();

    // Ramp pattern, ready held high.
    for (int i = 0; i < NB; i++) begin
      write_block(1'b0, i, 32'(i + 1));
      write_block(1'b1, i, 32'h1000_0000 + 32'(i));
    end
    run_stream(0, -1, -1, 1'b0, 1'b0, 0, 32'h0, 1'b0);

    // Downstream not ready for 50 cycles.
    run_stream(50, -1, -1, 1'b0, 1'b0, 0, 32'h0, 1'b0);

    // Writes and start during the stream are dropped; restream shows original data.
    run_stream(int'($urandom_range(0, 4)), int'($urandom_range(0, 120)), -1,
               1'b0, 1'b0, 0, 32'h0, 1'b0);
    run_stream(0, -1, -1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    chk("block5_n_kept", mdl_n[5], 32'd6);

    // Random reload, abort at beat 60 with reset, then full restream.
    for (int i = 0; i < NB; i++) begin
      write_block(1'b0, i, $urandom);
      write_block(1'b1, i, $urandom);
    end
    run_stream(int'($urandom_range(0, 3)), -1, 60, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    run_stream(0, -1, -1, 1'b0, 1'b0, 0, 32'h0, 1'b0);

    // Write immediately before start and in the start cycle; start in done cycle ignored.
    d = $urandom;
    write_block(1'b0, NB - 1, d);
    run_stream(int'($urandom_range(0, 3)), -1, -1, 1'b1, 1'b1, 0, $urandom, 1'b1);
    run_stream(0, -1, -1, 1'b0, 1'b0, 0, 32'h0, 1'b0);

    // Random partial reloads followed by streams.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++)
        write_block(1'($urandom), int'($urandom_range(0, NB - 1)), $urandom);
      run_stream(int'($urandom_range(0, 10)), -1, -1, 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, NB - 1)), $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
